// File: rtl/ysyx_23060061_mem_arbiter.sv
// Round-robin arbiter that lets an instruction-fetch port and a load/store port share one memory port.
// Optional watchdog: define YSYX_23060061_ARB_TIMEOUT_EN to abort stalled transactions with 0xDEADBEEF.
module ysyx_23060061_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_wen,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [3:0]        ls_wmask,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, last_grant_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wmask_q;
  logic [DATA_W-1:0] if_data_q, ls_data_q;
  logic              grant, rsp_fire, tmo_fire, timeout_hit;
  logic              rsp_load;
  logic [DATA_W-1:0] rsp_value;

  assign grant    = if_req_ready | ls_req_ready;
  assign rsp_fire = (state_q == WAIT) && mem_rsp_valid;
  // The watchdog only aborts when the memory has not just made progress this cycle.
  assign tmo_fire = timeout_hit &&
                    (((state_q == REQ) && !mem_req_ready) || ((state_q == WAIT) && !mem_rsp_valid));
  assign rsp_load  = rsp_fire | tmo_fire;
  assign rsp_value = rsp_fire ? mem_rsp_data : DATA_W'(32'hDEADBEEF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant) state_d = REQ;
      REQ: begin
        if (mem_req_ready)    state_d = WAIT;
        else if (timeout_hit) state_d = RESP;
      end
      WAIT: if (mem_rsp_valid || timeout_hit) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    if_rsp_valid  = 1'b0;
    ls_rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if_req_ready = if_req_valid && (!ls_req_valid || (last_grant_q == OWN_LS));
        ls_req_ready = ls_req_valid && (!if_req_valid || (last_grant_q == OWN_IF));
      end
      REQ:  mem_req_valid = 1'b1;
      RESP: begin
        if_rsp_valid = (owner_q == OWN_IF);
        ls_rsp_valid = (owner_q == OWN_LS);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_IF;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= 4'b0000;
      if_data_q    <= '0;
      ls_data_q    <= '0;
    end else begin
      if (grant) begin
        owner_q      <= ls_req_ready;
        last_grant_q <= ls_req_ready;
        wen_q        <= ls_req_ready & ls_wen;
        addr_q       <= ls_req_ready ? ls_addr  : if_addr;
        wdata_q      <= ls_req_ready ? ls_wdata : '0;
        wmask_q      <= ls_req_ready ? ls_wmask : 4'b0000;
      end
      // Each requester keeps its own data register so the idle side's rsp_data never moves.
      if (rsp_load) begin
        if (owner_q == OWN_LS) ls_data_q <= rsp_value;
        else                   if_data_q <= rsp_value;
      end
    end
  end

  assign mem_wen     = wen_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wmask   = wmask_q;
  assign if_rsp_data = if_data_q;
  assign ls_rsp_data = ls_data_q;

`ifdef YSYX_23060061_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wdog_q;
  logic             err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (grant)                                      wdog_q <= '0;
      else if ((state_q == REQ) || (state_q == WAIT)) wdog_q <= wdog_q + CNT_W'(1);
      if (grant)         err_q <= 1'b0;
      else if (tmo_fire) err_q <= 1'b1;
    end
  end

  // Fires on the last of TIMEOUT cycles spent in REQ plus WAIT.
  assign timeout_hit = ((state_q == REQ) || (state_q == WAIT)) && (wdog_q >= CNT_W'(TIMEOUT - 1));
  assign rsp_err     = (state_q == RESP) && err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT;
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: doc/ysyx_23060061_mem_arbiter.md
YSYX_23060061_MEM_ARBITER -- requirements
Module: ysyx_23060061_mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 255, watchdog limit in cycles.
REQ-002 SHALL have ports: clk input 1, single clock; rst input 1, asynchronous active-low reset.
REQ-003 SHALL have IF-side ports: if_req_valid in 1; if_req_ready out 1; if_addr in ADDR_W; if_rsp_valid out 1; if_rsp_data out DATA_W.
REQ-004 SHALL have LS-side ports: ls_req_valid in 1; ls_req_ready out 1; ls_wen in 1, 1 = write; ls_addr in ADDR_W; ls_wdata in DATA_W; ls_wmask in 4, byte enables; ls_rsp_valid out 1; ls_rsp_data out DATA_W.
REQ-005 SHALL have memory-side ports: mem_req_valid out 1; mem_req_ready in 1; mem_wen out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_wmask out 4; mem_rsp_valid in 1; mem_rsp_data in DATA_W.
REQ-006 SHALL have rsp_err out 1, flagging a timed-out response.

Function
REQ-007 SHALL implement FSM states IDLE, REQ, WAIT and RESP, with one outstanding memory transaction at most.
REQ-008 In IDLE, SHALL assert exactly one req_ready combinationally, for the winning valid requester; a handshake latches that requester's fields plus an owner bit, then moves to REQ.
REQ-009 IF requests SHALL be latched with wen=0, wdata=0 and wmask=4'b0000.
REQ-010 On a simultaneous IF/LS request, SHALL grant the requester not granted last (round-robin); last_grant updates on every grant.
REQ-011 In REQ, SHALL drive mem_req_valid=1 with the latched fields held stable; on mem_req_ready=1, SHALL move to WAIT.
REQ-012 In WAIT, SHALL sample mem_rsp_valid; on 1, SHALL latch mem_rsp_data and move to RESP.
REQ-013 Writes SHALL also complete via mem_rsp_valid as an acknowledgement.
REQ-014 mem_rsp_valid SHALL be ignored outside WAIT.
REQ-015 In RESP, SHALL pulse the owner's rsp_valid for exactly 1 cycle with the latched data on its rsp_data, then return to IDLE.
REQ-016 Requesters have no rsp_ready and SHALL accept the response.
REQ-017 The non-owner's rsp_valid SHALL stay 0 and its rsp_data SHALL stay at its last value.
REQ-018 Both req_ready outputs SHALL be 0 in REQ, WAIT and RESP.
REQ-019 A new request SHALL be granted no earlier than the cycle after RESP.
REQ-020 Minimum latency SHALL be 3 cycles from the accept edge to rsp_valid: REQ at +1, WAIT at +2, RESP at +3, given immediate mem_req_ready and mem_rsp_valid.
REQ-021 Outside REQ, mem_req_valid SHALL be 0.

Reset
REQ-022 On rst=0, SHALL go immediately to IDLE, regardless of clk.
REQ-023 During reset, all outputs except the req_ready pair SHALL be 0, and last_grant SHALL be IF.
REQ-024 Reset SHALL clear the watchdog counter and latched data.
REQ-025 A reset mid-transaction SHALL drop it silently, with no rsp_valid.

Configuration
REQ-026 With macro YSYX_23060061_ARB_TIMEOUT_EN defined, a counter SHALL count cycles spent in REQ plus WAIT.
REQ-027 With the macro defined, the counter SHALL clear on each grant.
REQ-028 With the macro defined, if the counter reaches TIMEOUT before mem_rsp_valid, SHALL latch data 32'hDEADBEEF and go to RESP.
REQ-029 With the macro defined, SHALL assert rsp_err=1 for that RESP cycle only.
REQ-030 With the macro undefined, there SHALL be no counter and rsp_err SHALL be tied 0; the FSM waits indefinitely.

Verification
REQ-031 IF read 0x80000000 alone; mem ready/rsp immediate with 0x00000413 -> if_rsp_valid 3 cycles after accept; data 0x00000413; ls_rsp_valid=0.
REQ-032 IF and LS valid in the same cycle right after reset -> LS granted first; IF granted after LS RESP; second conflict grants LS after IF.
REQ-033 LS write addr 0x80001000, wdata 0x12345678, wmask 4'b0011; mem_req_ready held 0 for 5 cycles -> mem fields stable throughout; ls_rsp_valid after ack.
REQ-034 rst driven 0 in WAIT, between clock edges -> mem_req_valid=0 and state IDLE immediately; late mem_rsp_valid ignored.
REQ-035 With the macro defined and TIMEOUT=4, mem never responds -> owner rsp_valid with 0xDEADBEEF and rsp_err=1; next request serviced normally.
REQ-036 Back-to-back IF-only requests -> a grant every 4 cycles; if_req_ready=0 during REQ, WAIT and RESP.
